// File: rtl/grad_pkg.sv
// Shared definitions for the gradient DAC serial sequencer: frame layout,
// FSM state encoding and status bit positions for register readback.
package grad_pkg;

    localparam int FRAME_W = 24;
    localparam int CH_LSB  = 24;
    localparam int CH_W    = 2;
    localparam int WORD_W  = CH_W + FRAME_W;

    // Status register bit positions (overflow sticky flag, FIFO full)
    localparam int STAT_OVF_BIT  = 0;
    localparam int STAT_BUSY_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } grad_state_e;

    // Strip the ignored upper bits of a BRAM word: keep {channel, frame}
    function automatic logic [WORD_W-1:0] pack_word(input logic [31:0] word);
        return word[CH_LSB+CH_W-1:0];
    endfunction

endpackage

// File: rtl/grad_sync_fifo.sv
// Small synchronous FIFO with occupancy count. A push and a pop in the
// same cycle are both honoured, including when the FIFO is full.
module grad_sync_fifo
    import grad_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify requests against occupancy; a pop frees the slot a full push needs
    always_comb begin
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        if (i_pop && (r_count != ZERO_CNT)) begin
            w_do_pop = 1'b1;
        end else begin
            w_do_pop = 1'b0;
        end
        if (i_push && ((r_count != FULL_CNT) || w_do_pop)) begin
            w_do_push = 1'b1;
        end else begin
            w_do_push = 1'b0;
        end
    end

    // Storage array and write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
        end
    end

    // Read pointer and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= ZERO_CNT;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/grad_serial_sched.sv
// Gradient DAC serial sequencer: buffers timed words from the BRAM stage and
// shifts each out as a 24-bit SPI frame on one of NCH chip-selects. busy_o
// back-pressures the BRAM stage whenever the FIFO is full.
module grad_serial_sched #(
    parameter int NCH        = 4,
    parameter int DEPTH      = 4,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic            S_AXI_ACLK,
    input  logic            rst_i,
    input  logic [31:0]     data_i,
    input  logic            valid_i,
    output logic            busy_o,
    output logic            sclk_o,
    output logic            mosi_o,
    output logic [NCH-1:0]  cs_n_o,
    output logic            overflow_o,
    input  logic            clear_i,
    output logic [15:0]     frame_cnt_o
);

    import grad_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);
    localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [4:0]    LAST_BIT = 5'(FRAME_W - 1);

    // Active-low one-hot select for a channel; out-of-range selects nothing
    function automatic logic [NCH-1:0] cs_decode(input logic [CH_W-1:0] ch);
        logic [NCH-1:0] v;
        v = {NCH{1'b1}};
        for (int i = 0; i < NCH; i++) begin
            if (ch == CH_W'(i)) begin
                v[i] = 1'b0;
            end else begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // FIFO interface
    logic [WORD_W-1:0] w_fifo_data;
    logic [CW-1:0]     w_count;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_unused_bits;

    // Sequencer state
    grad_state_e       r_state;
    grad_state_e       w_state_nxt;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] w_shift_nxt;
    logic [4:0]        r_bit;
    logic [4:0]        w_bit_nxt;
    logic [15:0]       r_tmr;
    logic [15:0]       w_tmr_nxt;
    logic              r_sclk;
    logic              w_sclk_nxt;
    logic              r_mosi;
    logic              w_mosi_nxt;
    logic [NCH-1:0]    r_cs_n;
    logic [NCH-1:0]    w_cs_n_nxt;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       w_frame_cnt_nxt;
    logic              r_ovf;

    assign w_unused_bits = ^data_i[31:CH_LSB+CH_W];

    // Accept when space exists or the sequencer frees a slot this same cycle
    always_comb begin
        w_push = 1'b0;
        w_drop = 1'b0;
        if (valid_i) begin
            w_push = (w_count != FULL_CNT) || w_pop;
            w_drop = !w_push;
        end else begin
            w_push = 1'b0;
            w_drop = 1'b0;
        end
    end

    grad_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (S_AXI_ACLK),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  (pack_word(data_i)),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count)
    );

    // Next-state and datapath: frame load, SCLK phase timing, bit shifting
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_nxt       = r_bit;
        w_tmr_nxt       = r_tmr;
        w_sclk_nxt      = r_sclk;
        w_mosi_nxt      = r_mosi;
        w_cs_n_nxt      = r_cs_n;
        w_frame_cnt_nxt = r_frame_cnt;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count != ZERO_CNT) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data[FRAME_W-1:0];
                    w_bit_nxt   = LAST_BIT;
                    w_mosi_nxt  = w_fifo_data[FRAME_W-1];
                    w_cs_n_nxt  = cs_decode(w_fifo_data[WORD_W-1:FRAME_W]);
                    w_tmr_nxt   = 16'd0;
                    w_sclk_nxt  = 1'b0;
                    w_state_nxt = SHIFT;
                end else begin
                    w_mosi_nxt  = 1'b0;
                    w_sclk_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                if (r_tmr == DIV_LAST) begin
                    w_tmr_nxt = 16'd0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // Falling edge: either finish or present the next bit
                        w_sclk_nxt = 1'b0;
                        if (r_bit == 5'd0) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
                            w_mosi_nxt  = r_shift[FRAME_W-2];
                            w_bit_nxt   = r_bit - 5'd1;
                        end
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 16'd1;
                end
            end
            HOLD: begin
                if (r_tmr == DIV_LAST) begin
                    w_tmr_nxt       = 16'd0;
                    w_cs_n_nxt      = {NCH{1'b1}};
                    w_mosi_nxt      = 1'b0;
                    w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    w_state_nxt     = GAP;
                end else begin
                    w_tmr_nxt = r_tmr + 16'd1;
                end
            end
            GAP: begin
                if (r_tmr == GAP_LAST) begin
                    w_tmr_nxt   = 16'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + 16'd1;
                end
            end
            default: begin
                w_cs_n_nxt  = {NCH{1'b1}};
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = 1'b0;
                w_tmr_nxt   = 16'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered SPI outputs; reset aborts any frame in flight
    always_ff @(posedge S_AXI_ACLK or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_shift     <= {FRAME_W{1'b0}};
            r_bit       <= 5'd0;
            r_tmr       <= 16'd0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= {NCH{1'b1}};
            r_frame_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit       <= w_bit_nxt;
            r_tmr       <= w_tmr_nxt;
            r_sclk      <= w_sclk_nxt;
            r_mosi      <= w_mosi_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // Sticky overflow flag; a drop wins over a same-cycle clear
    always_ff @(posedge S_AXI_ACLK or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clear_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign busy_o      = (w_count == FULL_CNT);
    assign sclk_o      = r_sclk;
    assign mosi_o      = r_mosi;
    assign cs_n_o      = r_cs_n;
    assign overflow_o  = r_ovf;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_grad_serial_sched.sv
// Self-checking bench for grad_serial_sched: table-driven frame vectors with a
// scoreboard queue checked by a bus monitor, plus hand-written corner cases.
module tb_grad_serial_sched;

    localparam logic [3:0] ALL1 = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic        valid_i;
    logic        clear_i;
    logic        busy_o;
    logic        sclk_o;
    logic        mosi_o;
    logic [3:0]  cs_n_o;
    logic        overflow_o;
    logic [15:0] frame_cnt_o;

    always #5 clk = ~clk;

    grad_serial_sched #(
        .NCH(4), .DEPTH(4), .CLK_DIV(2), .GAP_CYCLES(2)
    ) dut (
        .S_AXI_ACLK  (clk),
        .rst_i       (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .busy_o      (busy_o),
        .sclk_o      (sclk_o),
        .mosi_o      (mosi_o),
        .cs_n_o      (cs_n_o),
        .overflow_o  (overflow_o),
        .clear_i     (clear_i),
        .frame_cnt_o (frame_cnt_o)
    );

    typedef struct packed {
        logic [3:0]  cs;
        logic [23:0] frame;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  cs;
        logic [23:0] frame;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    int          starts[$];
    logic        in_frame = 1'b0;
    logic [3:0]  prev_cs  = 4'hF;
    logic        prev_sclk = 1'b0;
    logic [23:0] bits;
    int          rises;
    int          start_cyc;
    exp_t        cur;
    logic [15:0] exp_frames = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: pops the scoreboard at each frame start, checks at frame end
    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            prev_cs   = ALL1;
            prev_sclk = 1'b0;
        end else begin
            if (!in_frame && prev_cs == ALL1 && cs_n_o != ALL1) begin
                in_frame  = 1'b1;
                bits      = 24'd0;
                rises     = 0;
                start_cyc = cyc;
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    cur = '0;
                    $display("FAIL unexpected_frame actual cs=%b expected no frame", cs_n_o);
                end else begin
                    cur = exp_q.pop_front();
                    chk("cs_select", {28'd0, cs_n_o}, {28'd0, cur.cs});
                    chk("mosi_first", {31'd0, mosi_o}, {31'd0, cur.frame[23]});
                end
            end else if (in_frame) begin
                if (!prev_sclk && sclk_o) begin
                    bits  = {bits[22:0], mosi_o};
                    rises = rises + 1;
                end
                if (cs_n_o == ALL1) begin
                    chk("sclk_rises", rises, 24);
                    chk("mosi_data", {8'd0, bits}, {8'd0, cur.frame});
                    chk("cs_low_cycles", cyc - start_cyc, 98);
                    chk("frame_cnt_step", {16'd0, frame_cnt_o}, {16'd0, 16'(exp_frames + 16'd1)});
                    chk("sclk_idle", {31'd0, sclk_o}, 32'd0);
                    exp_frames = exp_frames + 16'd1;
                    in_frame   = 1'b0;
                end else if (cs_n_o != cur.cs) begin
                    chk("cs_stable", {28'd0, cs_n_o}, {28'd0, cur.cs});
                end
            end
            prev_cs   = cs_n_o;
            prev_sclk = sclk_o;
        end
    end

    function automatic logic [3:0] cs_of(input logic [31:0] d);
        logic [3:0] v;
        v = ALL1;
        v[d[25:24]] = 1'b0;
        return v;
    endfunction

    task automatic send(input logic [31:0] d, input logic accept);
        exp_t e;
        data_i  = d;
        valid_i = 1'b1;
        if (accept) begin
            e.cs    = cs_of(d);
            e.frame = d[23:0];
            exp_q.push_back(e);
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout actual=%0d cycles expected drain", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rises(input int cnt);
        int n = 0;
        int r = 0;
        logic p;
        p = sclk_o;
        while (r < cnt && n < 400) begin
            @(negedge clk);
            n++;
            if (!p && sclk_o) r++;
            p = sclk_o;
        end
        if (r < cnt) begin
            n_checks++;
            n_err++;
            $display("FAIL sclk_wait actual=%0d rises expected=%0d", r, cnt);
        end
    endtask

    task automatic wait_cs_rise();
        int n = 0;
        logic [3:0] p;
        p = cs_n_o;
        while (!(p != ALL1 && cs_n_o == ALL1) && n < 300) begin
            p = cs_n_o;
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_err++;
            $display("FAIL cs_rise_wait actual=%0d cycles expected cs release", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   v_cyc;
        logic [15:0] base;

        vecs[0] = '{32'h00C3C3C3, 4'b1110, 24'hC3C3C3};
        vecs[1] = '{32'h01123456, 4'b1101, 24'h123456};
        vecs[2] = '{32'h02ABCDEF, 4'b1011, 24'hABCDEF};
        vecs[3] = '{32'h03800001, 4'b0111, 24'h800001};
        vecs[4] = '{32'hFCFFFFFF, 4'b1110, 24'hFFFFFF};
        vecs[5] = '{32'h01000000, 4'b1101, 24'h000000};
        vecs[6] = '{32'hFF5A5A5A, 4'b0111, 24'h5A5A5A};
        vecs[7] = '{32'h02000001, 4'b1011, 24'h000001};

        rst = 1'b1; valid_i = 1'b0; clear_i = 1'b0; data_i = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {28'd0, cs_n_o}, {28'd0, ALL1});
        chk("rst_sclk", {31'd0, sclk_o}, 32'd0);
        chk("rst_mosi", {31'd0, mosi_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word on channel 1
        starts.delete();
        v_cyc = cyc;
        send(32'h01A5A5A5, 1'b1);
        wait_idle(300, "single");
        chk("single_frames", starts.size(), 1);
        if (starts.size() > 0) chk("single_latency", starts[0] - v_cyc, 2);
        chk("single_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);

        // Table vectors, two back-to-back batches of four
        for (int b = 0; b < 2; b++) begin
            starts.delete();
            for (int i = 0; i < 4; i++) send(vecs[b*4+i].data, 1'b1);
            wait_idle(800, "batch");
            chk("batch_frames", starts.size(), 4);
            for (int i = 1; i < starts.size(); i++) chk("batch_period", starts[i] - starts[i-1], 101);
        end
        chk("batch_frame_cnt", {16'd0, frame_cnt_o}, 32'd9);

        // Full / overflow with one frame in flight
        base = exp_frames;
        send(32'h00111111, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) chk("busy_before_4th", {31'd0, busy_o}, 32'd0);
            if (i == 4) chk("busy_after_4th", {31'd0, busy_o}, 32'd1);
            send(32'h00200000 + i, (i < 4) ? 1'b1 : 1'b0);
        end
        chk("ovf_set", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("ovf_clear", {31'd0, overflow_o}, 32'd0);
        clear_i = 1'b1;
        send(32'h03777777, 1'b0);
        clear_i = 1'b0;
        chk("ovf_clear_vs_drop", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("ovf_clear2", {31'd0, overflow_o}, 32'd0);
        wait_idle(800, "overflow");
        chk("ovf_frames", {16'd0, 16'(exp_frames - base)}, 32'd5);
        chk("ovf_frame_cnt", {16'd0, frame_cnt_o}, {16'd0, 16'(base + 16'd5)});

        // Push at full coinciding with the IDLE pop
        base = exp_frames;
        send(32'h02333333, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) send(32'h01400000 + i, 1'b1);
        chk("full_busy", {31'd0, busy_o}, 32'd1);
        wait_cs_rise();
        repeat (2) @(negedge clk);
        send(32'h03C0FFEE, 1'b1);
        chk("same_cycle_ovf", {31'd0, overflow_o}, 32'd0);
        chk("same_cycle_busy", {31'd0, busy_o}, 32'd1);
        wait_idle(900, "same_cycle");
        chk("same_cycle_frames", {16'd0, 16'(exp_frames - base)}, 32'd6);

        // Reset in the middle of a frame
        send(32'h00ABCDEF, 1'b1);
        wait_rises(10);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", {28'd0, cs_n_o}, {28'd0, ALL1});
        chk("mid_rst_sclk", {31'd0, sclk_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        chk("mid_rst_fifo_count", {29'd0, dut.w_count}, 32'd0);
        exp_q.delete();
        exp_frames = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'h00123456, 1'b1);
        wait_idle(300, "post_reset");
        chk("post_reset_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);

        // Frame counter wrap
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        chk("wrap_preset", {16'd0, frame_cnt_o}, 32'h0000FFFF);
        exp_frames = 16'hFFFF;
        send(32'h02FEDCBA, 1'b1);
        wait_idle(300, "wrap");
        chk("wrap_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/grad_serial_sched.md
Name: grad_serial_sched

Overview:
Sequencer between the gradient BRAM readout and the gradient DAC serial bus. It accepts timed 32-bit words from the BRAM output stage and buffers them in a small FIFO. It shifts each word out as a 24-bit SPI frame to one of NCH DAC chip-selects. It drives back the busy flag that the BRAM stage uses to stall or flag lost output, so the readout can never outrun the serial link.

Parameters:
NCH, 4, number of DAC chip-selects; channel field width is clog2(NCH), max 4 channels.
DEPTH, 4, FIFO depth in words (power of 2, >=2).
CLK_DIV, 2, system cycles per SCLK half-period (>=1).
GAP_CYCLES, 2, minimum cycles cs_n held high between frames (>=1).

Ports:
S_AXI_ACLK  in  1  system clock, shared with the BRAM/AXI domain
rst_i  in  1  asynchronous, active-high reset
data_i  in  32  word from BRAM stage: [25:24] channel, [23:0] DAC frame, [31:26] ignored
valid_i  in  1  one-cycle strobe, data_i valid
busy_o  out  1  FIFO full; wired to the BRAM stage serial_busy_i
sclk_o  out  1  SPI clock, idle low
mosi_o  out  1  SPI data, MSB first, changes on SCLK falling edge
cs_n_o  out  NCH  active-low chip selects, one-hot-low during a frame
overflow_o  out  1  sticky: a word was dropped
clear_i  in  1  clears overflow_o
frame_cnt_o  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, busy_o=0, sclk_o=0, mosi_o=0, cs_n_o=all 1, overflow_o=0, frame_cnt_o=0. Any frame in progress is aborted immediately.
- FIFO push rules:
  - Push on valid_i when count<DEPTH.
  - When count==DEPTH, push is accepted only if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow_o is set the next cycle.
- busy_o = (count==DEPTH), combinational from the count register.
- overflow_o: clear_i clears it the next cycle. If clear_i and a drop occur in the same cycle, set wins.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - If FIFO is non-empty: pop; load shift reg with data[23:0] and bit counter=23.
  - Drive cs_n_o[ch]=0 and mosi_o=data[23] on the next cycle. Go to SHIFT.
  - A channel value >=NCH selects no chip-select: the frame is still clocked out and counted.
- SHIFT: per bit, sclk_o is low for CLK_DIV cycles, then high for CLK_DIV cycles. On each falling edge, shift left and present the next bit. After the 24th high phase, go to HOLD.
- HOLD: sclk_o low, cs_n held low for CLK_DIV cycles. Then cs_n all high, frame_cnt_o+1, go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Timing:
  - cs_n low time = 49*CLK_DIV cycles (98 at default).
  - Pop-to-pop period with a non-empty FIFO = 49*CLK_DIV + GAP_CYCLES + 1 cycles (101 at default).
- No output glitches: cs_n, sclk_o and mosi_o are registered.
- Pop latency: a word pushed into an empty FIFO while IDLE pops the following cycle. Its cs_n goes low 2 cycles after valid_i.

Decomposition:
- Shared package grad_pkg:
  - FRAME_W=24, CH_LSB=24, CH_W=2
  - fsm state enum {IDLE, SHIFT, HOLD, GAP}
  - overflow/busy bit positions for later status register readback
- One sub-module: grad_sync_fifo.
  - Parameterised width/depth, synchronous FIFO with count output.
  - Simultaneous push/pop at full is allowed; reset is async active-high.

Test Plan:
- Single word: data_i=0x01A5A5A5, one valid_i pulse.
  - cs_n_o=4'b1101 low 2 cycles later, for 98 cycles.
  - Exactly 24 SCLK rising edges; MOSI sampled on the rising edges reads 0xA5A5A5.
  - frame_cnt_o=1; other cs_n stay 1.
- Channel sweep: words with [25:24]=0,1,2,3 back-to-back.
  - cs_n_o goes 1110, 1101, 1011, 0111 in order.
  - Successive cs_n falling edges are 101 cycles apart.
- Full/overflow: with one frame in flight, push 5 words on consecutive cycles.
  - busy_o rises the cycle after the 4th push.
  - The 5th word is dropped and overflow_o=1.
  - Exactly 5 frames total are shifted and frame_cnt_o=5.
  - clear_i pulse then drops overflow_o next cycle.
- Same-cycle events:
  - At full, valid_i coincides with the IDLE pop: word accepted, overflow_o stays 0.
  - clear_i coincides with a drop: overflow_o=1.
- Reset mid-frame: assert rst_i at bit 10 of a frame.
  - Same cycle: cs_n_o=all 1, sclk_o=0, busy_o=0, FIFO empty, frame_cnt_o=0.
  - After release, a new word 0x00123456 transmits correctly on cs_n_o[0].
- Counter wrap: force frame_cnt to 0xFFFF, send one frame -> frame_cnt_o=0x0000.
